mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 16, address width; DATA_W, default 16, data width; AGE_LIMIT, default 8, I/O starvation threshold in cycles.
REQ-002 Clocking and reset SHALL be one clock, with synchronous active-low reset.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- d_req, d_we  in  1 each  CPU load/store request and write flag.
- d_addr  in  ADDR_W  CPU data address.
- d_wdata  in  DATA_W  CPU store data.
- f_req  in  1  instruction fetch request; reads only.
- f_addr  in  ADDR_W  fetch address, equal to the PC.
- io_req  in  1  display/IO reader request; reads only.
- io_addr  in  ADDR_W  IO read address.
- d_gnt, f_gnt, io_gnt  out  1 each  grant; access issued this cycle.
- d_rvalid, f_rvalid, io_rvalid  out  1 each  read data valid on rdata.
- rdata  out  DATA_W  shared read-return bus.
- mem_addr  out  ADDR_W  single-port RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DATA_W  RAM read data; 1-cycle synchronous latency.

Function
REQ-004 Arbitration SHALL be combinational from current req inputs and registered state, with at most one gnt high per cycle.
REQ-005 Priority order SHALL be: aged IO (age_cnt == AGE_LIMIT) first, then d_req, then f_req/io_req resolved by the rr pointer.
REQ-006 The rr pointer (1 bit, 0 favours fetch) SHALL toggle after any grant to fetch or IO, and SHALL hold otherwise.
REQ-007 The granted requester's addr SHALL drive mem_addr in the grant cycle. With no grant, mem_addr SHALL be 0 and mem_we SHALL be 0.
REQ-008 mem_we SHALL equal d_gnt & d_we. mem_wdata SHALL always equal d_wdata.
REQ-009 A granted read SHALL raise that requester's rvalid exactly one cycle after gnt. rdata SHALL equal mem_rdata and SHALL be meaningful only while an rvalid is high.
REQ-010 A granted write SHALL produce no rvalid.
REQ-011 The arbiter SHALL accept one grant per cycle, fully pipelined, with back-to-back grants to the same or different requesters allowed.
REQ-012 A requester SHALL hold req, addr, we and wdata stable until its gnt. A req dropped before gnt SHALL be abandoned with no side effect.
REQ-013 age_cnt SHALL increment while io_req & ~io_gnt, saturating at AGE_LIMIT. It SHALL clear on io_gnt or when io_req is low.
REQ-014 A registered return tag (valid plus 2-bit requester id) SHALL record each read grant and SHALL drive the rvalid outputs the following cycle.
REQ-015 Simultaneous d_req and aged io_req SHALL grant IO. d_req SHALL then be granted next cycle if still asserted and no other aged condition exists.
REQ-016 d_req held continuously SHALL starve fetch. IO SHALL remain bounded to at most AGE_LIMIT+1 cycles of wait.

Reset
REQ-017 While rst_n=0 at a clock edge, the return tag SHALL clear, rr SHALL be set to 0, and age_cnt SHALL be set to 0.
REQ-018 After reset, all rvalid outputs SHALL be 0 in the following cycle. A read granted in the cycle reset asserts SHALL be dropped.
REQ-019 Grant outputs SHALL be forced to 0 while rst_n=0, which also holds mem_we at 0.

Structure
REQ-020 Package mem_arb_pkg SHALL hold the ADDR_W and DATA_W defaults, the AGE_LIMIT default, and requester ids REQ_D=2'd0, REQ_F=2'd1, REQ_IO=2'd2.
REQ-021 The IO starvation counter SHALL be a single sub-module, mem_arb_age_ctr: inputs req, gnt; output aged.

Verification
REQ-022 Scenario, fetch read: f_req, f_addr=0x0010, mem returns 0xBEEF -> f_gnt in cycle N; f_rvalid in N+1 with rdata=0xBEEF.
REQ-023 Scenario, load preempts fetch: d_req read 0x0200 and f_req asserted in the same cycle -> d_gnt first, f_gnt next cycle; rvalids arrive in the same order.
REQ-024 Scenario, store: d_req, d_we, d_addr=0x0300, d_wdata=0x1234 -> mem_we=1 for exactly one cycle with mem_addr=0x0300; no rvalid.
REQ-025 Scenario, f/io rotation: f_req and io_req held constant, rr=0 -> grants alternate F, IO, F, IO.
REQ-026 Scenario, IO aging: d_req held high with io_req held high, AGE_LIMIT=8 -> io_gnt no later than 9 cycles after io_req rises; age_cnt then clears.
REQ-027 Scenario, reset mid-read: rst_n=0 in the cycle after f_gnt -> f_rvalid stays 0; rr=0 and age_cnt=0 after reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the three-port memory arbiter: default widths,
// the IO starvation threshold, requester ids and the read-return tag.
package mem_arb_pkg;

  localparam int ADDR_W_DEFAULT    = 16;
  localparam int DATA_W_DEFAULT    = 16;
  localparam int AGE_LIMIT_DEFAULT = 8;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_D  = 2'd0;
  localparam req_id_t REQ_F  = 2'd1;
  localparam req_id_t REQ_IO = 2'd2;

  // One outstanding read return: issued last cycle, data arrives this cycle.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } ret_tag_t;

endpackage

// File: rtl/mem_arb_age_ctr.sv
// IO starvation counter: counts consecutive cycles a request waits without a
// grant, saturating at AGE_LIMIT; 'aged' forces the next grant to IO.
module mem_arb_age_ctr
  import mem_arb_pkg::*;
#(
  parameter int AGE_LIMIT = AGE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic gnt,
  output logic aged
);

  // Extra headroom in the width keeps AGE_LIMIT=0 legal.
  localparam int CNT_W = $clog2(AGE_LIMIT + 2);

  logic [CNT_W-1:0] age_cnt_reg;

  // Count waiting cycles; a grant or a dropped request restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      age_cnt_reg <= '0;
    end else if (!req || gnt) begin
      age_cnt_reg <= '0;
    end else if (age_cnt_reg != CNT_W'(AGE_LIMIT)) begin
      age_cnt_reg <= age_cnt_reg + 1'b1;
    end
  end

  assign aged = (age_cnt_reg == CNT_W'(AGE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for CPU data, instruction fetch and an IO reader.
// One access per cycle; read data returns one cycle later on a shared bus,
// steered to the right requester by a registered return tag.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int AGE_LIMIT = AGE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              io_req,
  input  logic [ADDR_W-1:0] io_addr,
  output logic              d_gnt,
  output logic              f_gnt,
  output logic              io_gnt,
  output logic              d_rvalid,
  output logic              f_rvalid,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic     rr_reg, rr_next;     // 0 favours fetch, 1 favours IO
  ret_tag_t tag_reg, tag_next;
  logic     io_aged;

  mem_arb_age_ctr #(
    .AGE_LIMIT (AGE_LIMIT)
  ) u_age_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (io_req),
    .gnt   (io_gnt),
    .aged  (io_aged)
  );

  // Grant selection: aged IO, then CPU data, then fetch/IO by round robin.
  always_comb begin
    d_gnt  = 1'b0;
    f_gnt  = 1'b0;
    io_gnt = 1'b0;
    if (rst_n) begin
      // The counter may still read aged in the cycle IO drops its request.
      if (io_req && io_aged) begin
        io_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end else if (f_req && io_req) begin
        if (rr_reg) io_gnt = 1'b1;
        else        f_gnt  = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end else if (io_req) begin
        io_gnt = 1'b1;
      end
    end
  end

  // RAM address/write steering plus next round-robin pointer and return tag.
  always_comb begin
    mem_addr  = '0;
    mem_we    = d_gnt & d_we;
    mem_wdata = d_wdata;
    rr_next   = rr_reg;
    tag_next  = '0;
    if (d_gnt) begin
      mem_addr       = d_addr;
      tag_next.valid = ~d_we;
      tag_next.id    = REQ_D;
    end else if (f_gnt) begin
      mem_addr       = f_addr;
      rr_next        = ~rr_reg;
      tag_next.valid = 1'b1;
      tag_next.id    = REQ_F;
    end else if (io_gnt) begin
      mem_addr       = io_addr;
      rr_next        = ~rr_reg;
      tag_next.valid = 1'b1;
      tag_next.id    = REQ_IO;
    end
  end

  // Arbiter state: round-robin pointer and the one-deep return tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_reg  <= 1'b0;
      tag_reg <= '0;
    end else begin
      rr_reg  <= rr_next;
      tag_reg <= tag_next;
    end
  end

  // A return in flight when reset asserts is suppressed immediately.
  assign d_rvalid  = rst_n && tag_reg.valid && (tag_reg.id == REQ_D);
  assign f_rvalid  = rst_n && tag_reg.valid && (tag_reg.id == REQ_F);
  assign io_rvalid = rst_n && tag_reg.valid && (tag_reg.id == REQ_IO);
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scenario tasks check grants and
// RAM port values inline; expected read returns go to a scoreboard queue
// that a negedge monitor pops and compares against rvalid/rdata.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int AL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          d_req = 1'b0, d_we = 1'b0, f_req = 1'b0, io_req = 1'b0;
  logic [AW-1:0] d_addr = '0, f_addr = '0, io_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, f_gnt, io_gnt, d_rvalid, f_rvalid, io_rvalid, mem_we;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic        exp_rr = 1'b0;
  logic [15:0] mem_model [0:65535];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .AGE_LIMIT(AL)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .f_req(f_req), .f_addr(f_addr),
    .io_req(io_req), .io_addr(io_addr),
    .d_gnt(d_gnt), .f_gnt(f_gnt), .io_gnt(io_gnt),
    .d_rvalid(d_rvalid), .f_rvalid(f_rvalid), .io_rvalid(io_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port RAM, one cycle read latency, read-before-write.
  always @(posedge clk) begin
    mem_rdata <= mem_model[mem_addr];
    if (mem_we) mem_model[mem_addr] <= mem_wdata;
  end

  // Scoreboard monitor: the entry due this cycle defines the rvalid pattern.
  always @(negedge clk) begin : monitor
    logic [2:0]  ev;
    logic [15:0] ed;
    exp_t        e;
    if (mon_en) begin
      ev = 3'b000;
      ed = '0;
      while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        e = sb_q.pop_front();
        failures++;
        $display("FAIL sb_stale: entry id=%0d due=%0d never returned (cycle %0d)", e.id, e.due, cyc);
      end
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        e  = sb_q.pop_front();
        ev = (e.id == REQ_D) ? 3'b100 : (e.id == REQ_F) ? 3'b010 : 3'b001;
        ed = e.data;
      end
      checks++;
      if ({d_rvalid, f_rvalid, io_rvalid} !== ev) begin
        failures++;
        $display("FAIL rvalid: cycle %0d got %b expected %b", cyc, {d_rvalid, f_rvalid, io_rvalid}, ev);
      end
      if (ev != 3'b000) begin
        checks++;
        if (rdata !== ed) begin
          failures++;
          $display("FAIL rdata: cycle %0d got %h expected %h", cyc, rdata, ed);
        end else begin
          $display("cycle %0d return rvalid=%b rdata=%h", cyc, ev, rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    d_req  = 1'b0;
    d_we   = 1'b0;
    f_req  = 1'b0;
    io_req = 1'b0;
  endtask

  task automatic sb_push(input logic [1:0] id, input logic [15:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    e.due  = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0300;
    f_req = 1'b1; io_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({d_gnt, f_gnt, io_gnt} !== 3'b000) begin
        failures++;
        $display("FAIL reset_gnt: got %b expected 000", {d_gnt, f_gnt, io_gnt});
      end
      checks++;
      if (mem_we !== 1'b0) begin
        failures++;
        $display("FAIL reset_we: got %b expected 0", mem_we);
      end
    end
    mon_en = 1'b1;
    tick();
    rst_n = 1'b1;
    clear_reqs();
    exp_rr = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_gnt, f_gnt, io_gnt, mem_we, mem_addr} !== {4'b0000, 16'h0000}) begin
      failures++;
      $display("FAIL idle_after_reset: got gnt=%b we=%b addr=%h expected 000/0/0000",
               {d_gnt, f_gnt, io_gnt}, mem_we, mem_addr);
    end
    $display("cycle %0d reset released, idle", cyc);
  endtask

  task automatic test_fetch_read();
    tick();
    f_req = 1'b1; f_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if ({d_gnt, f_gnt, io_gnt} !== 3'b010 || mem_addr !== 16'h0010 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL fetch_gnt: got gnt=%b addr=%h we=%b expected 010/0010/0",
               {d_gnt, f_gnt, io_gnt}, mem_addr, mem_we);
    end
    sb_push(REQ_F, 16'hBEEF);
    exp_rr = ~exp_rr;
    $display("cycle %0d fetch read 0010", cyc);
    tick();
    f_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_gnt, f_gnt, io_gnt} !== 3'b000) begin
      failures++;
      $display("FAIL fetch_idle: got %b expected 000", {d_gnt, f_gnt, io_gnt});
    end
  endtask

  task automatic test_load_preempt();
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
    f_req = 1'b1; f_addr = 16'h0040;
    @(negedge clk);
    checks++;
    if ({d_gnt, f_gnt, io_gnt} !== 3'b100 || mem_addr !== 16'h0200) begin
      failures++;
      $display("FAIL preempt_d: got gnt=%b addr=%h expected 100/0200", {d_gnt, f_gnt, io_gnt}, mem_addr);
    end
    sb_push(REQ_D, 16'h0200 ^ 16'h5A5A);
    $display("cycle %0d load 0200 granted ahead of fetch", cyc);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_gnt, f_gnt, io_gnt} !== 3'b010 || mem_addr !== 16'h0040) begin
      failures++;
      $display("FAIL preempt_f: got gnt=%b addr=%h expected 010/0040", {d_gnt, f_gnt, io_gnt}, mem_addr);
    end
    sb_push(REQ_F, 16'h0040 ^ 16'h5A5A);
    exp_rr = ~exp_rr;
    $display("cycle %0d fetch 0040 granted", cyc);
    tick();
    f_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store();
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0300; d_wdata = 16'h1234;
    @(negedge clk);
    checks++;
    if ({d_gnt, f_gnt, io_gnt} !== 3'b100 || mem_we !== 1'b1 ||
        mem_addr !== 16'h0300 || mem_wdata !== 16'h1234) begin
      failures++;
      $display("FAIL store: got gnt=%b we=%b addr=%h wdata=%h expected 100/1/0300/1234",
               {d_gnt, f_gnt, io_gnt}, mem_we, mem_addr, mem_wdata);
    end
    $display("cycle %0d store 0300 <= 1234", cyc);
    tick();
    d_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_gnt, mem_we, mem_addr} !== {2'b10, 16'h0300}) begin
      failures++;
      $display("FAIL store_readback: got gnt=%b we=%b addr=%h expected 1/0/0300", d_gnt, mem_we, mem_addr);
    end
    sb_push(REQ_D, 16'h1234);
    tick();
    clear_reqs();
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0 || {d_gnt, f_gnt, io_gnt} !== 3'b000) begin
      failures++;
      $display("FAIL store_idle: got we=%b gnt=%b expected 0/000", mem_we, {d_gnt, f_gnt, io_gnt});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    for (int i = 0; i < 4; i++) begin
      tick();
      a = 16'h0800 + 16'(i * 2);
      f_req = 1'b1; f_addr = a;
      @(negedge clk);
      checks++;
      if ({d_gnt, f_gnt, io_gnt} !== 3'b010 || mem_addr !== a) begin
        failures++;
        $display("FAIL b2b[%0d]: got gnt=%b addr=%h expected 010/%h", i, {d_gnt, f_gnt, io_gnt}, mem_addr, a);
      end
      sb_push(REQ_F, a ^ 16'h5A5A);
      exp_rr = ~exp_rr;
      $display("cycle %0d back-to-back fetch %h", cyc, a);
    end
    tick();
    clear_reqs();
    @(negedge clk);
  endtask

  task automatic test_io_aging();
    logic [2:0]  eg;
    logic [15:0] ea;
    for (int k = 0; k < 18; k++) begin
      tick();
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0600;
      io_req = 1'b1; io_addr = 16'h0700;
      @(negedge clk);
      eg = (k == 8 || k == 17) ? 3'b001 : 3'b100;
      ea = (eg == 3'b001) ? 16'h0700 : 16'h0600;
      checks++;
      if ({d_gnt, f_gnt, io_gnt} !== eg || mem_addr !== ea) begin
        failures++;
        $display("FAIL aging[%0d]: got gnt=%b addr=%h expected %b/%h", k, {d_gnt, f_gnt, io_gnt}, mem_addr, eg, ea);
      end
      if (eg == 3'b001) begin
        sb_push(REQ_IO, 16'h0700 ^ 16'h5A5A);
        exp_rr = ~exp_rr;
      end else begin
        sb_push(REQ_D, 16'h0600 ^ 16'h5A5A);
      end
      $display("cycle %0d aging step %0d gnt=%b", cyc, k, {d_gnt, f_gnt, io_gnt});
    end
    tick();
    clear_reqs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    tick();
    f_req = 1'b1; f_addr = 16'h0020;
    @(negedge clk);
    checks++;
    if ({d_gnt, f_gnt, io_gnt} !== 3'b010) begin
      failures++;
      $display("FAIL midrst_gnt: got %b expected 010", {d_gnt, f_gnt, io_gnt});
    end
    tick();
    rst_n = 1'b0;
    f_req = 1'b0; d_req = 1'b1; d_we = 1'b1;
    @(negedge clk);
    checks++;
    if (f_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_rvalid: got %b expected 0", f_rvalid);
    end
    checks++;
    if ({d_gnt, f_gnt, io_gnt, mem_we} !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_forced: got gnt=%b we=%b expected 000/0", {d_gnt, f_gnt, io_gnt}, mem_we);
    end
    $display("cycle %0d reset during fetch return", cyc);
    tick();
    rst_n = 1'b1;
    clear_reqs();
    exp_rr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rotation();
    logic [2:0]  eg;
    logic [15:0] ea;
    for (int i = 0; i < 4; i++) begin
      tick();
      f_req = 1'b1; f_addr = 16'h0100;
      io_req = 1'b1; io_addr = 16'h0500;
      @(negedge clk);
      eg = exp_rr ? 3'b001 : 3'b010;
      ea = exp_rr ? 16'h0500 : 16'h0100;
      checks++;
      if ({d_gnt, f_gnt, io_gnt} !== eg || mem_addr !== ea) begin
        failures++;
        $display("FAIL rotation[%0d]: got gnt=%b addr=%h expected %b/%h", i, {d_gnt, f_gnt, io_gnt}, mem_addr, eg, ea);
      end
      sb_push(exp_rr ? REQ_IO : REQ_F, ea ^ 16'h5A5A);
      exp_rr = ~exp_rr;
      $display("cycle %0d rotation step %0d gnt=%b", cyc, i, {d_gnt, f_gnt, io_gnt});
    end
    tick();
    clear_reqs();
    @(negedge clk);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem_model[a] = 16'(a) ^ 16'h5A5A;
    mem_model[16'h0010] = 16'hBEEF;
    test_reset();
    test_fetch_read();
    test_load_preempt();
    test_store();
    test_back_to_back();
    test_io_aging();
    test_reset_mid_read();
    test_rotation();
    tick();
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
